// File: rtl/key_tone_decoder_pkg.sv
// rtl/key_tone_decoder_pkg.sv - note table, code range and FSM encodings for key_tone_decoder
package key_tone_decoder_pkg;

    localparam int CODE_MAX = 21;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    // C-major from C4, three octaves; 0 marks a silent code
    function automatic int unsigned note_hz(input int unsigned code);
        case (code)
            1:       return 262;
            2:       return 294;
            3:       return 330;
            4:       return 349;
            5:       return 392;
            6:       return 440;
            7:       return 494;
            8:       return 523;
            9:       return 587;
            10:      return 659;
            11:      return 698;
            12:      return 784;
            13:      return 880;
            14:      return 988;
            15:      return 1047;
            16:      return 1175;
            17:      return 1319;
            18:      return 1397;
            19:      return 1568;
            20:      return 1760;
            21:      return 1976;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/key_tone_decoder_tone_divider.sv
// rtl/key_tone_decoder_tone_divider.sv - half-period counter driving a toggle flop
module tone_divider #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] half_period,
    output logic             sq
);

    logic [CNT_W-1:0] half_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt <= '0;
            sq       <= 1'b0;
        end else if (clear) begin
            half_cnt <= '0;
            sq       <= 1'b0;
        end else if (half_cnt == half_period - CNT_W'(1)) begin
            half_cnt <= '0;
            sq       <= ~sq;
        end else begin
            half_cnt <= half_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_tone_decoder.sv
// rtl/key_tone_decoder.sv - debounces key codes and plays the matching note as a square wave
module key_tone_decoder
    import key_tone_decoder_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_code,
    input  logic       mute,
    output logic       speaker,
    output logic       playing,
    output logic [4:0] active_code,
    output logic       code_strobe
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic [4:0]        cand;
    logic [STAB_W-1:0] stab_cnt;
    logic [0:0]        state;
    logic [CNT_W-1:0]  half_period;
    logic              accept;
    logic              accept_valid;
    logic              sq;

    // Half-period table folded to constants at elaboration
    logic [CNT_W-1:0] hp_lut [32];
    for (genvar g = 0; g < 32; g++) begin : g_lut
        localparam int unsigned HZ  = note_hz(g);
        localparam int unsigned DIV = (HZ == 0) ? 1 : 2 * HZ;
        assign hp_lut[g] = (HZ == 0) ? '0 : CNT_W'(CLK_FREQ_HZ / DIV);
    end

    assign accept       = (key_code == cand) && (stab_cnt == STAB_LAST) && (cand != active_code);
    assign accept_valid = (cand != 5'd0) && (cand <= 5'(CODE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand        <= '0;
            stab_cnt    <= '0;
            active_code <= '0;
            code_strobe <= 1'b0;
            state       <= ST_IDLE;
            half_period <= '0;
        end else begin
            code_strobe <= accept;
            if (key_code != cand) begin
                cand     <= key_code;
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_LAST) begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end
            if (accept) begin
                active_code <= cand;
                if (accept_valid) begin
                    state       <= ST_PLAY;
                    half_period <= hp_lut[cand];
                end else begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    // An accept restarts the tone at phase 0, taking priority over a wrap
    tone_divider #(
        .CNT_W(CNT_W)
    ) u_tone_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept || mute || (state != ST_PLAY)),
        .half_period(half_period),
        .sq         (sq)
    );

    assign speaker = sq;
    assign playing = (state == ST_PLAY);

endmodule

// File: tb/tb_key_tone_decoder.sv
// tb/tb_key_tone_decoder.sv - scoreboard bench for key_tone_decoder
module tb_key_tone_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key_code;
    logic       mute;
    logic       speaker;
    logic       playing;
    logic [4:0] active_code;
    logic       code_strobe;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        int unsigned code;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    key_tone_decoder #(
        .CLK_FREQ_HZ  (1_000_000),
        .STABLE_CYCLES(4),
        .CNT_W        (18)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .mute       (mute),
        .speaker    (speaker),
        .playing    (playing),
        .active_code(active_code),
        .code_strobe(code_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [4:0] v, output int unsigned e);
        @(posedge clk);
        #1;
        key_code = v;
        e = cyc;
    endtask

    task automatic wait_cycle(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_accept(input int unsigned code, input int unsigned at);
        exp_t x;
        x.code = code;
        x.cyc  = at;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n && code_strobe) begin
            chk("strobe_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("strobe_code", active_code, mon_e.code);
                chk("strobe_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e, a, m, r;

        rst_n    = 1'b0;
        key_code = 5'd0;
        mute     = 1'b0;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk("rst_speaker", speaker, 0);
        chk("rst_playing", playing, 0);
        chk("rst_active", active_code, 0);
        chk("rst_strobe", code_strobe, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_strobe", code_strobe, 0);
        end
        chk("idle_playing", playing, 0);
        chk("idle_speaker", speaker, 0);
        chk("idle_active", active_code, 0);

        // 2: code 6 (440 Hz -> 1136)
        drive(5'd6, e);
        a = e + 5;
        expect_accept(6, a);
        wait_cycle(a - 1);
        chk("c6_pre_active", active_code, 0);
        wait_cycle(a);
        chk("c6_active", active_code, 6);
        chk("c6_playing", playing, 1);
        chk("c6_spk_at_accept", speaker, 0);
        wait_cycle(a + 1135);
        chk("c6_spk_before_rise", speaker, 0);
        wait_cycle(a + 1136);
        chk("c6_spk_rise", speaker, 1);
        wait_cycle(a + 2271);
        chk("c6_spk_high", speaker, 1);
        wait_cycle(a + 2272);
        chk("c6_spk_fall", speaker, 0);

        // 3: back to 0, then bounce 6,3,6,6,6,6
        drive(5'd0, e);
        expect_accept(0, e + 5);
        wait_cycle(e + 5);
        chk("zero_playing", playing, 0);
        drive(5'd6, e);
        expect_accept(6, e + 7);
        drive(5'd3, m);
        drive(5'd6, m);
        wait_cycle(e + 6);
        chk("bounce_not_yet", active_code, 0);
        wait_cycle(e + 7);
        chk("bounce_active", active_code, 6);
        chk("bounce_playing", playing, 1);

        // 4: switch 1 -> 21 mid-tone, then 0
        drive(5'd1, e);
        a = e + 5;
        expect_accept(1, a);
        wait_cycle(a + 1908 + 5);
        chk("c1_spk_high", speaker, 1);
        drive(5'd21, e);
        a = e + 5;
        expect_accept(21, a);
        wait_cycle(a - 1);
        chk("c21_spk_before", speaker, 1);
        wait_cycle(a);
        chk("c21_spk_cleared", speaker, 0);
        chk("c21_active", active_code, 21);
        wait_cycle(a + 252);
        chk("c21_spk_before_rise", speaker, 0);
        wait_cycle(a + 253);
        chk("c21_spk_rise", speaker, 1);
        wait_cycle(a + 506);
        chk("c21_spk_fall", speaker, 0);
        drive(5'd0, e);
        expect_accept(0, e + 5);
        wait_cycle(e + 5);
        chk("c0_playing", playing, 0);
        chk("c0_speaker", speaker, 0);

        // 5: out-of-range code, then code 8 (523 Hz -> 956) with mute
        drive(5'd25, e);
        expect_accept(25, e + 5);
        wait_cycle(e + 5);
        chk("c25_active", active_code, 25);
        chk("c25_playing", playing, 0);
        wait_cycle(e + 300);
        chk("c25_speaker", speaker, 0);
        drive(5'd8, e);
        a = e + 5;
        expect_accept(8, a);
        wait_cycle(a + 955);
        chk("c8_spk_before_rise", speaker, 0);
        wait_cycle(a + 956);
        chk("c8_spk_rise", speaker, 1);
        wait_cycle(a + 1000);
        @(posedge clk);
        #1 mute = 1'b1;
        m = cyc;
        wait_cycle(m + 1);
        chk("mute_spk", speaker, 0);
        chk("mute_playing", playing, 1);
        chk("mute_active", active_code, 8);
        wait_cycle(m + 1200);
        chk("mute_spk_held", speaker, 0);
        @(posedge clk);
        #1 mute = 1'b0;
        r = cyc;
        wait_cycle(r + 955);
        chk("unmute_before_rise", speaker, 0);
        wait_cycle(r + 956);
        chk("unmute_rise", speaker, 1);

        // 6: async reset while speaker is high
        #2 rst_n = 1'b0;
        #1;
        chk("arst_speaker", speaker, 0);
        chk("arst_playing", playing, 0);
        chk("arst_active", active_code, 0);
        chk("arst_strobe", code_strobe, 0);
        key_code = 5'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        e = cyc;
        wait_cycle(e + 10);
        chk("post_rst_playing", playing, 0);
        chk("post_rst_speaker", speaker, 0);
        chk("post_rst_active", active_code, 0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
